// File: rtl/culsans_pkg.sv
// culsans_pkg
// Shared AXI/ACE channel types for the coherent read path.
//   - ar_chan_t / r_chan_t         : per-core channels, IdWidth-bit ids.
//   - arb_ar_chan_t / arb_r_chan_t : merged channels; the id is widened by
//                                    the core index, {core, id}.
//   - ArbMaxOutstanding            : default in-flight AR burst limit.
//   - widen_ar()                   : helper that prefixes the core index.
package culsans_pkg;

   localparam int NB_CORES          = 2;
   localparam int IdWidth           = 4;
   localparam int AddrWidth         = 64;
   localparam int DataWidth         = 64;
   localparam int UserWidth         = 1;
   localparam int CoreIdxWidth      = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
   localparam int ArbIdWidth        = IdWidth + CoreIdxWidth;
   localparam int ArbMaxOutstanding = 4;

   typedef logic [IdWidth-1:0]    id_t;
   typedef logic [ArbIdWidth-1:0] arb_id_t;

   typedef struct packed {
      id_t                  id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [3:0]           snoop;
      logic [1:0]           domain;
      logic [1:0]           bar;
      logic [UserWidth-1:0] user;
   } ar_chan_t;

   typedef struct packed {
      arb_id_t              id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [3:0]           snoop;
      logic [1:0]           domain;
      logic [1:0]           bar;
      logic [UserWidth-1:0] user;
   } arb_ar_chan_t;

   typedef struct packed {
      id_t                  id;
      logic [DataWidth-1:0] data;
      logic [3:0]           resp;
      logic                 last;
      logic [UserWidth-1:0] user;
   } r_chan_t;

   typedef struct packed {
      arb_id_t              id;
      logic [DataWidth-1:0] data;
      logic [3:0]           resp;
      logic                 last;
      logic [UserWidth-1:0] user;
   } arb_r_chan_t;

   // Copy every AR field unchanged and prefix the id with the core index.
   function automatic arb_ar_chan_t widen_ar(input ar_chan_t ar,
                                             input logic [CoreIdxWidth-1:0] core);
      arb_ar_chan_t res;
      res.id     = {core, ar.id};
      res.addr   = ar.addr;
      res.len    = ar.len;
      res.size   = ar.size;
      res.burst  = ar.burst;
      res.lock   = ar.lock;
      res.cache  = ar.cache;
      res.prot   = ar.prot;
      res.qos    = ar.qos;
      res.region = ar.region;
      res.snoop  = ar.snoop;
      res.domain = ar.domain;
      res.bar    = ar.bar;
      res.user   = ar.user;
      return res;
   endfunction

endpackage

// File: rtl/culsans_rr_select.sv
// culsans_rr_select
// Combinational round-robin picker: the first set request at or after
// ptr (wrapping modulo N) wins.
//   req     : request vector
//   ptr     : index with highest priority this cycle (must be < N)
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted requester
//   any     : at least one request present
module culsans_rr_select #(
   parameter  int N    = 2,
   localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [IdxW-1:0] gnt_idx,
   output logic            any
);

   int cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      cand    = 0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr) + k) % N;
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = IdxW'(cand);
         end
      end
   end

endmodule

// File: rtl/culsans_ar_arbiter.sv
// culsans_ar_arbiter
// Merges the coherent AR channels of NbCores cores into one AR channel and
// routes the shared R channel back by the core index carried in the id.
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   slv_ar_i/_valid_i/_ready_o         : per-core AR requests
//   slv_r_o/_valid_o, slv_r_ready_i    : per-core R responses
//   mst_ar_o/_valid_o, mst_ar_ready_i  : merged AR, id = {core, id}
//   mst_r_i/_valid_i, mst_r_ready_o    : merged R
//   perf_grant_cnt_o                   : per-core grant counters
// Optional feature: define CULSANS_AR_ARB_PERF_EN to build saturating grant
// counters; otherwise perf_grant_cnt_o is constant zero.
module culsans_ar_arbiter
   import culsans_pkg::*;
#(
   parameter int NbCores        = culsans_pkg::NB_CORES,
   parameter int MaxOutstanding = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  ar_chan_t            slv_ar_i [NbCores],
   input  logic [NbCores-1:0]  slv_ar_valid_i,
   output logic [NbCores-1:0]  slv_ar_ready_o,
   output r_chan_t             slv_r_o [NbCores],
   output logic [NbCores-1:0]  slv_r_valid_o,
   input  logic [NbCores-1:0]  slv_r_ready_i,
   output arb_ar_chan_t        mst_ar_o,
   output logic                mst_ar_valid_o,
   input  logic                mst_ar_ready_i,
   input  arb_r_chan_t         mst_r_i,
   input  logic                mst_r_valid_i,
   output logic                mst_r_ready_o,
   output logic [31:0]         perf_grant_cnt_o [NbCores]
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;
   localparam int CoreW = (NbCores > 1) ? $clog2(NbCores) : 1;
   localparam int CntW  = $clog2(MaxOutstanding + 1);

   logic [0:0]         state_reg;
   logic [CoreW-1:0]   rr_reg;
   logic [CoreW-1:0]   gnt_idx_reg;
   logic [CntW-1:0]    out_cnt_reg;
   arb_ar_chan_t       ar_reg;

   logic [NbCores-1:0] rr_gnt;
   logic [CoreW-1:0]   rr_idx;
   logic               rr_any;
   logic               can_grant;
   logic               ar_hs;
   logic               mst_hs;
   logic               r_dec;

   culsans_rr_select #(.N(NbCores)) u_rr_select (
      .req     (slv_ar_valid_i),
      .ptr     (rr_reg),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx),
      .any     (rr_any)
   );

   // Grants only from IDLE, never during reset, and only below the limit.
   assign can_grant      = (state_reg == IDLE) && !rst_i &&
                           (out_cnt_reg < CntW'(MaxOutstanding));
   assign slv_ar_ready_o = can_grant ? rr_gnt : '0;
   assign ar_hs          = can_grant && rr_any;
   assign mst_hs         = (state_reg == HOLD) && mst_ar_ready_i;
   assign mst_ar_valid_o = (state_reg == HOLD);
   assign mst_ar_o       = ar_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         rr_reg      <= '0;
         gnt_idx_reg <= '0;
         ar_reg      <= '0;
      end else if (ar_hs) begin
         state_reg   <= HOLD;
         gnt_idx_reg <= rr_idx;
         ar_reg      <= widen_ar(slv_ar_i[rr_idx], CoreIdxWidth'(rr_idx));
      end else if (mst_hs) begin
         state_reg <= IDLE;
         rr_reg    <= (gnt_idx_reg == CoreW'(NbCores - 1)) ? '0
                                                         : gnt_idx_reg + CoreW'(1);
      end
   end

   // In-flight bursts: +1 per accepted AR, -1 per final R beat.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_cnt_reg <= '0;
      end else if (ar_hs && !r_dec) begin
         out_cnt_reg <= out_cnt_reg + CntW'(1);
      end else if (!ar_hs && r_dec && (out_cnt_reg != '0)) begin
         out_cnt_reg <= out_cnt_reg - CntW'(1);
      end
   end

   // ---------------- R routing ----------------
   logic [CoreIdxWidth-1:0] r_core;
   logic                    r_core_ok;

   assign r_core = mst_r_i.id[ArbIdWidth-1 -: CoreIdxWidth];

   // An index field wider than needed can name a core that does not exist.
   generate
      if ((1 << CoreIdxWidth) > NbCores) begin : g_core_chk
         assign r_core_ok = (int'(r_core) < NbCores);
      end else begin : g_core_all
         assign r_core_ok = 1'b1;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < NbCores; gi++) begin : g_r_out
         assign slv_r_o[gi] = '{id:   mst_r_i.id[IdWidth-1:0],
                                data: mst_r_i.data,
                                resp: mst_r_i.resp,
                                last: mst_r_i.last,
                                user: mst_r_i.user};
         assign slv_r_valid_o[gi] = mst_r_valid_i && r_core_ok && (int'(r_core) == gi);
      end
   endgenerate

   // Responses for nonexistent cores are sunk so the interconnect never stalls.
   always_comb begin
      mst_r_ready_o = 1'b1;
      for (int i = 0; i < NbCores; i++) begin
         if (r_core_ok && (int'(r_core) == i)) begin
            mst_r_ready_o = slv_r_ready_i[i];
         end
      end
   end

   assign r_dec = mst_r_valid_i && mst_r_ready_o && mst_r_i.last && r_core_ok;

   // ---------------- Performance counters ----------------
`ifdef CULSANS_AR_ARB_PERF_EN
   generate
      for (gi = 0; gi < NbCores; gi++) begin : g_perf
         logic [31:0] cnt_reg;
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               cnt_reg <= '0;
            end else if (slv_ar_valid_i[gi] && slv_ar_ready_o[gi] && (cnt_reg != '1)) begin
               cnt_reg <= cnt_reg + 32'd1;
            end
         end
         assign perf_grant_cnt_o[gi] = cnt_reg;
      end
   endgenerate
`else
   generate
      for (gi = 0; gi < NbCores; gi++) begin : g_perf_off
         assign perf_grant_cnt_o[gi] = '0;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_culsans_ar_arbiter.sv
// tb_culsans_ar_arbiter
// Randomized bench for culsans_ar_arbiter checked against a transaction-level
// model (pending request, round-robin pointer, in-flight count, grant tallies).
// Honours CULSANS_AR_ARB_PERF_EN for the expected counter values.
module tb_culsans_ar_arbiter;
   import culsans_pkg::*;

   localparam int NB   = NB_CORES;
   localparam int MAXO = 4;

   logic             clk_i = 1'b0;
   logic             rst_i;
   ar_chan_t         slv_ar_i [NB];
   logic [NB-1:0]    slv_ar_valid_i;
   logic [NB-1:0]    slv_ar_ready_o;
   r_chan_t          slv_r_o [NB];
   logic [NB-1:0]    slv_r_valid_o;
   logic [NB-1:0]    slv_r_ready_i;
   arb_ar_chan_t     mst_ar_o;
   logic             mst_ar_valid_o;
   logic             mst_ar_ready_i;
   arb_r_chan_t      mst_r_i;
   logic             mst_r_valid_i;
   logic             mst_r_ready_o;
   logic [31:0]      perf_grant_cnt_o [NB];

   always #5 clk_i = ~clk_i;

   culsans_ar_arbiter #(.NbCores(NB), .MaxOutstanding(MAXO)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .slv_ar_i         (slv_ar_i),
      .slv_ar_valid_i   (slv_ar_valid_i),
      .slv_ar_ready_o   (slv_ar_ready_o),
      .slv_r_o          (slv_r_o),
      .slv_r_valid_o    (slv_r_valid_o),
      .slv_r_ready_i    (slv_r_ready_i),
      .mst_ar_o         (mst_ar_o),
      .mst_ar_valid_o   (mst_ar_valid_o),
      .mst_ar_ready_i   (mst_ar_ready_i),
      .mst_r_i          (mst_r_i),
      .mst_r_valid_i    (mst_r_valid_i),
      .mst_r_ready_o    (mst_r_ready_o),
      .perf_grant_cnt_o (perf_grant_cnt_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_value(input string tag, input logic [127:0] got,
                              input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model state ----------------
   bit           m_hold;
   int           m_core;
   arb_ar_chan_t m_pay;
   int           m_rr;
   int           m_out;
   int           m_cnt [NB];

   function automatic ar_chan_t rand_ar();
      ar_chan_t a;
      a.id     = 4'($urandom);
      a.addr   = {$urandom, $urandom};
      a.len    = 8'($urandom);
      a.size   = 3'($urandom);
      a.burst  = 2'($urandom);
      a.lock   = 1'($urandom);
      a.cache  = 4'($urandom);
      a.prot   = 3'($urandom);
      a.qos    = 4'($urandom);
      a.region = 4'($urandom);
      a.snoop  = 4'($urandom);
      a.domain = 2'($urandom);
      a.bar    = 2'($urandom);
      a.user   = 1'($urandom);
      return a;
   endfunction

   // Expected merged request: id is core * 2^IdWidth + original id.
   function automatic arb_ar_chan_t expect_ar(input ar_chan_t a, input int core);
      arb_ar_chan_t e;
      e.id     = arb_id_t'(core * (1 << IdWidth) + int'(a.id));
      e.addr   = a.addr;
      e.len    = a.len;
      e.size   = a.size;
      e.burst  = a.burst;
      e.lock   = a.lock;
      e.cache  = a.cache;
      e.prot   = a.prot;
      e.qos    = a.qos;
      e.region = a.region;
      e.snoop  = a.snoop;
      e.domain = a.domain;
      e.bar    = a.bar;
      e.user   = a.user;
      return e;
   endfunction

   function automatic logic [31:0] exp_perf(input int c);
`ifdef CULSANS_AR_ARB_PERF_EN
      return 32'(m_cnt[c]);
`else
      return 32'(c - c);
`endif
   endfunction

   int ardy_pct [4] = '{80, 90, 10, 60};
   int rv_pct   [4] = '{30,  4, 20, 25};
   int rst_pct  [4] = '{ 0,  0,  0,  4};

   initial begin
      int            exp_core;
      logic [NB-1:0] exp_ready;
      logic [NB-1:0] exp_rvalid;
      logic          exp_mrdy;
      int            rc;
      int            ph;
      bit            hs;
      bit            dec;

      // Reset with every core requesting: nothing may be accepted.
      rst_i          = 1'b1;
      slv_ar_valid_i = '1;
      slv_r_ready_i  = '0;
      mst_ar_ready_i = 1'b0;
      mst_r_valid_i  = 1'b0;
      mst_r_i        = '0;
      for (int c = 0; c < NB; c++) slv_ar_i[c] = rand_ar();
      m_hold = 1'b0; m_core = 0; m_pay = '0; m_rr = 0; m_out = 0;
      for (int c = 0; c < NB; c++) m_cnt[c] = 0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      #1;
      check_value("rst_ar_ready", slv_ar_ready_o, '0);
      check_value("rst_mst_valid", mst_ar_valid_o, 1'b0);
      check_value("rst_mst_ar", mst_ar_o, '0);
      check_value("rst_r_valid", slv_r_valid_o, '0);
      for (int c = 0; c < NB; c++) check_value("rst_perf", perf_grant_cnt_o[c], 32'd0);

      for (int cyc = 0; cyc < 1600; cyc++) begin
         ph = cyc / 400;
         @(negedge clk_i);
         rst_i = ($urandom_range(99) < rst_pct[ph]);
         for (int c = 0; c < NB; c++) begin
            slv_ar_valid_i[c] = ($urandom_range(99) < 70);
            slv_ar_i[c]       = rand_ar();
         end
         slv_r_ready_i  = NB'($urandom);
         mst_ar_ready_i = ($urandom_range(99) < ardy_pct[ph]);
         mst_r_valid_i  = ($urandom_range(99) < rv_pct[ph]);
         mst_r_i.id     = arb_id_t'($urandom);
         mst_r_i.data   = {$urandom, $urandom};
         mst_r_i.resp   = 4'($urandom);
         mst_r_i.last   = 1'($urandom);
         mst_r_i.user   = 1'($urandom);
         #1;

         // Expected grant: first requester at or after the pointer.
         exp_core  = -1;
         exp_ready = '0;
         if (!rst_i && !m_hold && m_out < MAXO) begin
            for (int k = 0; k < NB; k++) begin
               int c;
               c = (m_rr + k) % NB;
               if (exp_core < 0 && slv_ar_valid_i[c]) exp_core = c;
            end
         end
         if (exp_core >= 0) exp_ready[exp_core] = 1'b1;

         rc         = int'(mst_r_i.id) / (1 << IdWidth);
         exp_rvalid = '0;
         exp_mrdy   = 1'b1;
         if (rc < NB) begin
            exp_rvalid[rc] = mst_r_valid_i;
            exp_mrdy       = slv_r_ready_i[rc];
         end

         $display("[TB] cyc %0d rst=%0b req=%b exp_gnt=%0d hold=%0b out=%0d rid=%0h rv=%0b",
                  cyc, rst_i, slv_ar_valid_i, exp_core, m_hold, m_out,
                  mst_r_i.id, mst_r_valid_i);

         check_value("slv_ar_ready", slv_ar_ready_o, exp_ready);
         check_value("mst_ar_valid", mst_ar_valid_o, m_hold);
         if (m_hold) check_value("mst_ar_payload", mst_ar_o, m_pay);
         check_value("slv_r_valid", slv_r_valid_o, exp_rvalid);
         check_value("mst_r_ready", mst_r_ready_o, exp_mrdy);
         if (mst_r_valid_i && rc < NB) begin
            check_value("slv_r_id", slv_r_o[rc].id, int'(mst_r_i.id) % (1 << IdWidth));
            check_value("slv_r_data", slv_r_o[rc].data, mst_r_i.data);
            check_value("slv_r_last", slv_r_o[rc].last, mst_r_i.last);
         end
         for (int c = 0; c < NB; c++) check_value("perf_cnt", perf_grant_cnt_o[c], exp_perf(c));

         @(posedge clk_i);
         if (rst_i) begin
            m_hold = 1'b0; m_rr = 0; m_out = 0; m_pay = '0;
            for (int c = 0; c < NB; c++) m_cnt[c] = 0;
         end else begin
            hs  = (exp_core >= 0);
            dec = mst_r_valid_i && exp_mrdy && mst_r_i.last && (rc < NB);
            if (m_hold && mst_ar_ready_i) begin
               m_hold = 1'b0;
               m_rr   = (m_core + 1) % NB;
            end
            if (hs) begin
               m_hold = 1'b1;
               m_core = exp_core;
               m_pay  = expect_ar(slv_ar_i[exp_core], exp_core);
               m_cnt[exp_core]++;
            end
            m_out = m_out + (hs ? 1 : 0) - (dec ? 1 : 0);
            if (m_out < 0)    m_out = 0;
            if (m_out > MAXO) m_out = MAXO;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
